axi_line_bridge: RTL and testbench

- Bus-side engine behind each directCache: turns one cache-line fill or writeback command into a single AXI4 INCR burst on the m_axi_* master interface.
- Streams fill beats back to the cache.
- Pulls writeback beats from the cache.
- Reports completion and error with a one-cycle pulse.
- One outstanding transaction at a time; the instruction and data caches each get one instance, or share one through an upstream arbiter.

---
 rtl/axi_line_bridge.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_line_bridge.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_line_bridge.sv
// ---------------------------------------------------------------------------
// axi_line_bridge
//
// Bus-side engine behind a directCache. It turns one cache-line fill or
// writeback command into a single AXI4 INCR burst of BEATS beats. Fill beats
// are streamed straight back to the cache. Writeback beats are pulled from the
// cache one handshake at a time. Completion is reported with a one-cycle done
// pulse, and err is qualified by done. Only one transaction is outstanding at
// a time.
//
// Ports
//   clk, reset           clock; synchronous active-low reset
//   cmd_*                line command from the cache (valid/ready, store, addr)
//   wr_data              current writeback beat supplied by the cache
//   wr_data_ready        writeback beat consumed; the cache advances next cycle
//   rd_data/rd_valid/rd_last  fill beat stream to the cache (no buffering)
//   done, err            completion pulse and its error flag
//   m_axi_*              AXI4 master read/write channels
// ---------------------------------------------------------------------------
module axi_line_bridge #(
    parameter int                  ID_WIDTH   = 13,
    parameter int                  ADDR_WIDTH = 64,
    parameter int                  DATA_WIDTH = 64,
    parameter int                  BEATS      = 8,
    parameter logic [ID_WIDTH-1:0] AXI_ID     = {ID_WIDTH{1'b0}}
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_store,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,

    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      wr_data_ready,

    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid,
    output logic                      rd_last,

    output logic                      done,
    output logic                      err,

    output logic [ID_WIDTH-1:0]       m_axi_awid,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awlock,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,

    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,

    input  logic [ID_WIDTH-1:0]       m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,

    output logic [ID_WIDTH-1:0]       m_axi_arid,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,

    input  logic [ID_WIDTH-1:0]       m_axi_rid,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(BEATS * (DATA_WIDTH / 8));

    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [7:0]            AX_LEN    = 8'(BEATS - 1);
    // Clears the byte-within-line offset so every burst starts line-aligned.
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    err_acc_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    last_beat_s;
    logic                    unused_ids_s;

    // IDs on the response channels carry no information for a single
    // outstanding transaction, so they are folded away here.
    assign unused_ids_s = ^{m_axi_rid, m_axi_bid};

    assign last_beat_s = (cnt_r == LAST_BEAT);

    // Every handshake signal is decoded from the state register only and
    // forced low while reset is asserted, so no valid depends on its ready.
    assign cmd_ready     = reset && (state_r == ST_IDLE);
    assign m_axi_arvalid = reset && (state_r == ST_AR);
    assign m_axi_rready  = reset && (state_r == ST_R);
    assign m_axi_awvalid = reset && (state_r == ST_AW);
    assign m_axi_wvalid  = reset && (state_r == ST_W);
    assign m_axi_bready  = reset && (state_r == ST_B);
    assign done          = reset && (state_r == ST_DONE);
    assign err           = done && err_acc_r;

    // Fill beats pass straight through; the cache never stalls them.
    assign rd_data  = m_axi_rdata;
    assign rd_valid = m_axi_rready && m_axi_rvalid;
    assign rd_last  = rd_valid && last_beat_s;

    assign m_axi_wdata   = wr_data;
    assign m_axi_wstrb   = {(DATA_WIDTH/8){1'b1}};
    assign m_axi_wlast   = m_axi_wvalid && last_beat_s;
    assign wr_data_ready = m_axi_wvalid && m_axi_wready;

    assign m_axi_arid    = AXI_ID;
    assign m_axi_araddr  = addr_r;
    assign m_axi_arlen   = AX_LEN;
    assign m_axi_arsize  = 3'b011;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0000;
    assign m_axi_arprot  = 3'b000;

    assign m_axi_awid    = AXI_ID;
    assign m_axi_awaddr  = addr_r;
    assign m_axi_awlen   = AX_LEN;
    assign m_axi_awsize  = 3'b011;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0000;
    assign m_axi_awprot  = 3'b000;

    // Transaction FSM: address phase, data beats, response, completion pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            err_acc_r <= 1'b0;
            addr_r    <= {ADDR_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_r  <= cmd_addr & LINE_MASK;
                        state_r <= cmd_store ? ST_AW : ST_AR;
                    end
                end
                ST_AR: begin
                    if (m_axi_arready) begin
                        state_r <= ST_R;
                    end
                end
                ST_R: begin
                    if (m_axi_rvalid) begin
                        cnt_r     <= cnt_r + CNT_W'(1);
                        // A misplaced rlast (early or missing) is an error, but
                        // the burst length stays BEATS regardless.
                        err_acc_r <= err_acc_r
                                   | (m_axi_rresp != 2'b00)
                                   | (m_axi_rlast != last_beat_s);
                        if (last_beat_s) begin
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_AW: begin
                    if (m_axi_awready) begin
                        state_r <= ST_W;
                    end
                end
                ST_W: begin
                    if (m_axi_wready) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (last_beat_s) begin
                            state_r <= ST_B;
                        end
                    end
                end
                ST_B: begin
                    if (m_axi_bvalid) begin
                        err_acc_r <= err_acc_r | (m_axi_bresp != 2'b00);
                        state_r   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    cnt_r     <= {CNT_W{1'b0}};
                    err_acc_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_line_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi_line_bridge
//
// Directed bench for axi_line_bridge. The initial block plays both the cache
// and the AXI slave. Fill data and writeback data are pushed onto scoreboard
// queues when they are driven, and popped when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_axi_line_bridge;

    localparam int IDW = 13;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int NB  = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid, cmd_ready, cmd_store;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   wr_data;
    logic            wr_data_ready;
    logic [DW-1:0]   rd_data;
    logic            rd_valid, rd_last, done, err;

    logic [IDW-1:0]  awid, arid, bid, rid;
    logic [AW-1:0]   awaddr, araddr;
    logic [7:0]      awlen, arlen;
    logic [2:0]      awsize, arsize, awprot, arprot;
    logic [1:0]      awburst, arburst, bresp, rresp;
    logic            awlock, arlock;
    logic [3:0]      awcache, arcache;
    logic            awvalid, awready, wlast, wvalid, wready;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic            bvalid, bready, arvalid, arready, rlast, rvalid, rready;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] rd_q[$];
    logic [63:0] wr_q[$];

    axi_line_bridge dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
        .cmd_addr(cmd_addr), .wr_data(wr_data), .wr_data_ready(wr_data_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .done(done), .err(err),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awlock(awlock),
        .m_axi_awcache(awcache), .m_axi_awprot(awprot),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
        .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
        .m_axi_arcache(arcache), .m_axi_arprot(arprot),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All handshake/status outputs packed together for the reset checks.
    function automatic logic [9:0] ctl_outs();
        return {awvalid, wvalid, bready, arvalid, rready,
                rd_valid, done, err, wr_data_ready, cmd_ready};
    endfunction

    // Fill: optional arready wait, rresp error beat, early rlast, cmd held
    // during R, or reset after abort_after beats (then returns early).
    task automatic do_fill(input logic [63:0] addr, input int err_beat,
                           input int early_last, input int ar_wait,
                           input bit hold_cmd, input int abort_after,
                           input bit exp_err);
        logic [63:0] exp_addr;
        logic [63:0] d;
        exp_addr = addr & ~64'h3F;
        cmd_valid = 1'b1; cmd_store = 1'b0; cmd_addr = addr;
        #1 check("fill_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk); #1; cmd_valid = 1'b0; cmd_addr = 64'hDEAD_BEEF_0000_0000;
        #1;
        check("arvalid", arvalid, 1'b1);
        check("araddr", araddr, exp_addr);
        check("arlen", arlen, 8'd7);
        check("arsize", arsize, 3'd3);
        check("arburst", arburst, 2'd1);
        check("ar_misc", {arid, arlock, arcache, arprot}, '0);
        check("rready_before_ar", rready, 1'b0);
        for (int w = 0; w < ar_wait; w++) begin
            @(posedge clk); #2;
            check("arvalid_held", arvalid, 1'b1);
            check("araddr_held", araddr, exp_addr);
            check("arlen_held", arlen, 8'd7);
            check("rready_during_ar", rready, 1'b0);
        end
        arready = 1'b1;
        @(posedge clk); #1; arready = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (b == abort_after) begin
                reset = 1'b0; rvalid = 1'b0;
                #1 check("reset_outs_now", ctl_outs(), 10'd0);
                @(posedge clk); #2;
                check("reset_outs_next", ctl_outs(), 10'd0);
                reset = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #2;
                    check("no_done_after_reset", done, 1'b0);
                    check("idle_after_reset", cmd_ready, 1'b1);
                end
                return;
            end
            d = {$urandom, $urandom};
            rvalid = 1'b1; rdata = d;
            rresp = (b == err_beat) ? 2'b10 : 2'b00;
            rlast = (early_last >= 0) ? (b == early_last) : (b == NB - 1);
            rd_q.push_back(d);
            if (hold_cmd) begin
                cmd_valid = 1'b1;
            end
            #1;
            check("rd_valid", rd_valid, 1'b1);
            check("rd_last", rd_last, (b == NB - 1));
            check("rready", rready, 1'b1);
            check("fill_busy", cmd_ready, 1'b0);
            if (rd_valid && rd_q.size() > 0) begin
                check("rd_data", rd_data, rd_q.pop_front());
            end
            @(posedge clk); #1;
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; cmd_valid = 1'b0;
        #1;
        check("fill_done", done, 1'b1);
        check("fill_err", err, exp_err);
        check("done_cmd_ready", cmd_ready, 1'b0);
        check("rd_valid_after", rd_valid, 1'b0);
        @(posedge clk); #2;
        check("done_pulse_width", done, 1'b0);
        check("fill_ready_again", cmd_ready, 1'b1);
    endtask

    // Writeback: the bench acts as the cache, presenting beat index wb on
    // wr_data and advancing it only after a handshake.
    task automatic do_wb(input logic [63:0] addr, input logic [1:0] resp,
                         input bit toggle, input bit exp_err);
        int wb;
        int cyc;
        cmd_valid = 1'b1; cmd_store = 1'b1; cmd_addr = addr;
        #1 check("wb_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk); #1; cmd_valid = 1'b0;
        #1;
        check("awvalid", awvalid, 1'b1);
        check("awaddr", awaddr, addr & ~64'h3F);
        check("awlen", awlen, 8'd7);
        check("awsize", awsize, 3'd3);
        check("awburst", awburst, 2'd1);
        check("wvalid_before_aw", wvalid, 1'b0);
        awready = 1'b1;
        @(posedge clk); #1; awready = 1'b0;
        for (int i = 0; i < NB; i++) begin
            wr_q.push_back(64'(i));
        end
        wb = 0;
        cyc = 0;
        while (wb < NB && cyc < 64) begin
            wr_data = 64'(wb);
            wready = toggle ? ((cyc % 2) == 0) : 1'b1;
            #1;
            check("wvalid", wvalid, 1'b1);
            check("wr_data_ready", wr_data_ready, wready);
            check("wlast", wlast, (wb == NB - 1));
            check("wstrb", wstrb, 8'hFF);
            if (wready && wr_q.size() > 0) begin
                check("wdata", wdata, wr_q.pop_front());
            end
            @(posedge clk); #1;
            if (wready) begin
                wb++;
            end
            cyc++;
        end
        check("w_beats_in_budget", 64'(wb), 64'(NB));
        wready = 1'b0;
        #1;
        check("bready", bready, 1'b1);
        check("wvalid_after", wvalid, 1'b0);
        bvalid = 1'b1; bresp = resp;
        @(posedge clk); #1; bvalid = 1'b0; bresp = 2'b00;
        #1;
        check("wb_done", done, 1'b1);
        check("wb_err", err, exp_err);
        @(posedge clk); #2;
        check("wb_done_pulse_width", done, 1'b0);
        check("wb_ready_again", cmd_ready, 1'b1);
    endtask

    // Linear directed sequence.
    initial begin
        reset = 1'b0;
        cmd_valid = 1'b0; cmd_store = 1'b0; cmd_addr = '0; wr_data = '0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = 2'b00; bvalid = 1'b0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
        rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #2 check("reset_outputs", ctl_outs(), 10'd0);
        @(posedge clk); #1; reset = 1'b1;
        #1 check("idle_ready", cmd_ready, 1'b1);

        // zero-wait fill
        do_fill(64'h8000_0038, -1, -1, 0, 1'b0, -1, 1'b0);
        // writeback with wready toggling 1,0,1,0
        do_wb(64'h1040, 2'b00, 1'b1, 1'b0);
        // rresp SLVERR on beat 3
        do_fill(64'h3000, 2, -1, 0, 1'b0, -1, 1'b1);
        // bresp DECERR, then a clean command clears the error
        do_wb(64'h5008, 2'b11, 1'b0, 1'b1);
        do_fill(64'h4000, -1, -1, 0, 1'b0, -1, 1'b0);
        // arready held low 5 cycles, cmd_valid asserted during R
        do_fill(64'h6010, -1, -1, 5, 1'b1, -1, 1'b0);
        // reset after 3 beats, then a fresh fill
        do_fill(64'h7000, -1, -1, 0, 1'b0, 3, 1'b0);
        rd_q.delete();
        do_fill(64'h2000, -1, -1, 0, 1'b0, -1, 1'b0);
        // early rlast on beat 6
        do_fill(64'h9000, -1, 5, 0, 1'b0, -1, 1'b1);

        check("rd_scoreboard_empty", 64'(rd_q.size()), 64'd0);
        check("wr_scoreboard_empty", 64'(wr_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
